bitslice_rst_seq: RTL and testbench
===================================

// Module: bitslice_rst_seq
// PURPOSE
//  Parametrised reset/VTC sequencer for the native-mode BITSLICE nibbles of the LVDS SGMII shared logic.
//  Generalises the fixed three-nibble sequence to NUM_NIBBLES nibbles with a per-nibble enable mask.
//  Adds lock-loss recovery, ready timeouts and an error status.
//  Sits between the TX/RX PLL lock outputs and the BITSLICE_CONTROL/BITSLICE reset and EN_VTC pins.
// PARAMETERS
//  NUM_NIBBLES     3       number of nibbles sequenced (1..8)
//  NIBBLE_MASK     3'b111  NUM_NIBBLES bits; a 0 bit means that nibble's dly_rdy/vtc_rdy are ignored
//  RST_HOLD_CYCLES 64      cycles per reset phase (>=1)
//  TIMEOUT_CYCLES  65535   maximum wait for all dly_rdy or all vtc_rdy (>=1)
// PORTS
//  clk          in   1            sequencer clock (riu_clk domain)
//  reset        in   1            synchronous, active-high
//  pll_locked   in   1            AND of tx/rx PLL locks; already synchronised to clk
//  dly_rdy      in   NUM_NIBBLES  BITSLICE_CONTROL DLY_RDY, one per nibble
//  vtc_rdy      in   NUM_NIBBLES  BITSLICE_CONTROL VTC_RDY, one per nibble
//  bsc_rst      out  1            BITSLICE_CONTROL reset
//  bs_rst       out  1            BITSLICE reset
//  rst_dly      out  1            delay-line reset
//  bsc_en_vtc   out  1            BITSLICE_CONTROL EN_VTC
//  bs_en_vtc    out  1            BITSLICE EN_VTC
//  logic_reset  out  1            fabric logic reset; released only in DONE
//  seq_done     out  1            sequence complete
//  seq_error    out  1            a timeout occurred
//  seq_state    out  4            current state encoding, for debug
// BEHAVIOUR
//  Reset values: bsc_rst=bs_rst=rst_dly=logic_reset=1; bsc_en_vtc=bs_en_vtc=seq_done=seq_error=0; state=WAIT_LOCK.
//  All outputs are registered and decoded from the state; an output changes 1 cycle after its state transition.
//  Readiness conditions:
//    all_dly = &(dly_rdy | ~NIBBLE_MASK)
//    all_vtc = &(vtc_rdy | ~NIBBLE_MASK)
//  One counter cnt, $clog2(max(RST_HOLD_CYCLES, TIMEOUT_CYCLES)+1) bits wide, cleared on every state entry. It never wraps.
//  States and transitions:
//    WAIT_LOCK(0)  all resets asserted. -> RST_ALL when pll_locked=1.
//    RST_ALL(1)    hold all resets RST_HOLD_CYCLES cycles. -> REL_BSC.
//    REL_BSC(2)    bsc_rst=0; bs_rst and rst_dly stay 1 for RST_HOLD_CYCLES cycles. -> REL_BS.
//    REL_BS(3)     bs_rst=0, rst_dly=0. -> WAIT_DLY next cycle.
//    WAIT_DLY(4)   -> EN_VTC when all_dly=1; -> ERROR when cnt reaches TIMEOUT_CYCLES-1.
//    EN_VTC(5)     bsc_en_vtc=1 and bs_en_vtc=1, and both stay 1 through DONE. -> WAIT_VTC.
//    WAIT_VTC(6)   -> DONE when all_vtc=1; -> ERROR when cnt reaches TIMEOUT_CYCLES-1.
//    DONE(7)       logic_reset=0, seq_done=1.
//    ERROR(8)      all resets re-asserted, en_vtc=0, seq_error=1.
//  Simultaneous ready and timeout on the same cycle: ready wins.
//  pll_locked=0 in any state other than WAIT_LOCK or ERROR: -> WAIT_LOCK next cycle, all outputs return to reset values. This overrides every other transition.
//  A ready input that drops after its wait state has been left is ignored.
//  reset asserted mid-sequence: the next cycle is identical to the power-up reset state.
//  NIBBLE_MASK all zero: WAIT_DLY and WAIT_VTC each last exactly 1 cycle.
// CONFIGURATION
//  BITSLICE_SEQ_RETRY_EN defined:
//    ERROR holds RST_HOLD_CYCLES cycles, then -> WAIT_LOCK.
//    seq_error stays 1 (sticky) until reset, including after a later successful DONE.
//  BITSLICE_SEQ_RETRY_EN undefined:
//    ERROR is terminal until reset; pll_locked is ignored while in ERROR.
// TESTING
//  1. NUM_NIBBLES=3, RST_HOLD_CYCLES=4. pll_locked=1 at cycle 10; dly_rdy=3'b111 two cycles after entering WAIT_DLY; vtc_rdy=3'b111 three cycles after entering WAIT_VTC
//     -> bsc_rst falls at cycle 15+1, bs_rst falls 4 cycles later, seq_done=1, logic_reset=0.
//  2. NIBBLE_MASK=3'b101, dly_rdy=3'b101, vtc_rdy=3'b101 -> reaches DONE; nibble 1 is never waited on.
//  3. TIMEOUT_CYCLES=16, dly_rdy stuck at 3'b011 -> ERROR after 16 cycles in WAIT_DLY, seq_error=1, bsc_rst=1.
//     With BITSLICE_SEQ_RETRY_EN: the sequence restarts. Without it: state stays 8.
//  4. pll_locked drops while in WAIT_VTC -> next state WAIT_LOCK, en_vtc=0, all resets=1. Relock -> full sequence repeats to DONE.
//  5. all_dly and the timeout condition true on the same cycle -> EN_VTC is entered, seq_error stays 0.
//  6. reset pulse while in DONE -> outputs return to reset values on the next cycle, state=0.

Source files
------------

// File: rtl/bitslice_rst_seq.sv
// rtl/bitslice_rst_seq.sv - reset/VTC sequencer for native-mode BITSLICE nibbles; optional BITSLICE_SEQ_RETRY_EN
module bitslice_rst_seq #(
  parameter int unsigned              NUM_NIBBLES     = 3,
  parameter logic [NUM_NIBBLES-1:0]   NIBBLE_MASK     = '1,
  parameter int unsigned              RST_HOLD_CYCLES = 64,
  parameter int unsigned              TIMEOUT_CYCLES  = 65535
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   pll_locked_i,
  input  logic [NUM_NIBBLES-1:0] dly_rdy_i,
  input  logic [NUM_NIBBLES-1:0] vtc_rdy_i,
  output logic                   bsc_rst_o,
  output logic                   bs_rst_o,
  output logic                   rst_dly_o,
  output logic                   bsc_en_vtc_o,
  output logic                   bs_en_vtc_o,
  output logic                   logic_reset_o,
  output logic                   seq_done_o,
  output logic                   seq_error_o,
  output logic [3:0]             seq_state_o
);

  localparam int unsigned CNT_MAX = (RST_HOLD_CYCLES > TIMEOUT_CYCLES) ? RST_HOLD_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

  typedef enum logic [3:0] {
    WAIT_LOCK = 4'd0,
    RST_ALL   = 4'd1,
    REL_BSC   = 4'd2,
    REL_BS    = 4'd3,
    WAIT_DLY  = 4'd4,
    EN_VTC    = 4'd5,
    WAIT_VTC  = 4'd6,
    DONE      = 4'd7,
    ERROR     = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic bsc_rst_q, bsc_rst_d;
  logic bs_rst_q, bs_rst_d;
  logic rst_dly_q, rst_dly_d;
  logic en_vtc_q, en_vtc_d;
  logic logic_reset_q, logic_reset_d;
  logic seq_done_q, seq_done_d;
  logic seq_error_q, seq_error_d;

  // Masked-off nibbles count as permanently ready.
  logic all_dly, all_vtc;
  assign all_dly = &(dly_rdy_i | ~NIBBLE_MASK);
  assign all_vtc = &(vtc_rdy_i | ~NIBBLE_MASK);

  // Next state, phase counter and output decode of the current state (outputs lag state by one cycle).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bsc_rst_d     = 1'b1;
    bs_rst_d      = 1'b1;
    rst_dly_d     = 1'b1;
    en_vtc_d      = 1'b0;
    logic_reset_d = 1'b1;
    seq_done_d    = 1'b0;
    seq_error_d   = 1'b0;

    case (state_q)
      WAIT_LOCK: if (pll_locked_i) state_d = RST_ALL;
      RST_ALL:   if (cnt_q == HOLD_LAST) state_d = REL_BSC;
      REL_BSC:   if (cnt_q == HOLD_LAST) state_d = REL_BS;
      REL_BS:    state_d = WAIT_DLY;
      WAIT_DLY: begin
        if (all_dly)                state_d = EN_VTC;
        else if (cnt_q == TMO_LAST) state_d = ERROR;
      end
      EN_VTC:    state_d = WAIT_VTC;
      WAIT_VTC: begin
        if (all_vtc)                state_d = DONE;
        else if (cnt_q == TMO_LAST) state_d = ERROR;
      end
      DONE:      state_d = DONE;
`ifdef BITSLICE_SEQ_RETRY_EN
      ERROR:     if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
`else
      ERROR:     state_d = ERROR;
`endif
      default:   state_d = WAIT_LOCK;
    endcase

    // Lock loss restarts the sequence from any active state.
    if (!pll_locked_i && (state_q != WAIT_LOCK) && (state_q != ERROR)) begin
      state_d = WAIT_LOCK;
    end

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;

    case (state_q)
      REL_BSC: bsc_rst_d = 1'b0;
      REL_BS, WAIT_DLY: begin
        bsc_rst_d = 1'b0;
        bs_rst_d  = 1'b0;
        rst_dly_d = 1'b0;
      end
      EN_VTC, WAIT_VTC: begin
        bsc_rst_d = 1'b0;
        bs_rst_d  = 1'b0;
        rst_dly_d = 1'b0;
        en_vtc_d  = 1'b1;
      end
      DONE: begin
        bsc_rst_d     = 1'b0;
        bs_rst_d      = 1'b0;
        rst_dly_d     = 1'b0;
        en_vtc_d      = 1'b1;
        logic_reset_d = 1'b0;
        seq_done_d    = 1'b1;
      end
      default: ;
    endcase

`ifdef BITSLICE_SEQ_RETRY_EN
    // Error flag survives retries so a recovered link still reports the earlier timeout.
    seq_error_d = seq_error_q | (state_q == ERROR);
`else
    seq_error_d = (state_q == ERROR);
`endif
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      bsc_rst_q     <= 1'b1;
      bs_rst_q      <= 1'b1;
      rst_dly_q     <= 1'b1;
      en_vtc_q      <= 1'b0;
      logic_reset_q <= 1'b1;
      seq_done_q    <= 1'b0;
      seq_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bsc_rst_q     <= bsc_rst_d;
      bs_rst_q      <= bs_rst_d;
      rst_dly_q     <= rst_dly_d;
      en_vtc_q      <= en_vtc_d;
      logic_reset_q <= logic_reset_d;
      seq_done_q    <= seq_done_d;
      seq_error_q   <= seq_error_d;
    end
  end

  assign bsc_rst_o     = bsc_rst_q;
  assign bs_rst_o      = bs_rst_q;
  assign rst_dly_o     = rst_dly_q;
  assign bsc_en_vtc_o  = en_vtc_q;
  assign bs_en_vtc_o   = en_vtc_q;
  assign logic_reset_o = logic_reset_q;
  assign seq_done_o    = seq_done_q;
  assign seq_error_o   = seq_error_q;
  assign seq_state_o   = state_q;

endmodule

// File: tb/tb_bitslice_rst_seq.sv
// tb/tb_bitslice_rst_seq.sv - scoreboard bench for bitslice_rst_seq
module tb_bitslice_rst_seq;

  // Output vector order: {bsc_rst, bs_rst, rst_dly, bsc_en_vtc, bs_en_vtc, logic_reset, seq_done, seq_error}
  localparam logic [7:0] O_RST  = 8'b1110_0100;
  localparam logic [7:0] O_RBSC = 8'b0110_0100;
  localparam logic [7:0] O_RBS  = 8'b0000_0100;
  localparam logic [7:0] O_VTC  = 8'b0001_1100;
  localparam logic [7:0] O_DONE = 8'b0001_1010;
  localparam logic [7:0] O_ERR  = 8'b1110_0101;

  localparam logic [3:0] S_WL = 4'd0, S_RA = 4'd1, S_RB = 4'd2, S_RS = 4'd3, S_WD = 4'd4;
  localparam logic [3:0] S_EV = 4'd5, S_WV = 4'd6, S_DN = 4'd7, S_ER = 4'd8;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic [2:0] dly_rdy, vtc_rdy;
  logic       bsc_rst, bs_rst, rst_dly, bsc_en_vtc, bs_en_vtc, logic_reset, seq_done, seq_error;
  logic [3:0] seq_state;

  always #5 clk = ~clk;

  bitslice_rst_seq #(
    .NUM_NIBBLES(3), .NIBBLE_MASK(3'b101), .RST_HOLD_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .reset_i(reset), .pll_locked_i(pll_locked),
    .dly_rdy_i(dly_rdy), .vtc_rdy_i(vtc_rdy),
    .bsc_rst_o(bsc_rst), .bs_rst_o(bs_rst), .rst_dly_o(rst_dly),
    .bsc_en_vtc_o(bsc_en_vtc), .bs_en_vtc_o(bs_en_vtc), .logic_reset_o(logic_reset),
    .seq_done_o(seq_done), .seq_error_o(seq_error), .seq_state_o(seq_state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] out;
    logic [7:0] dur;
    logic       imm;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [7:0] out, input int dur, input bit imm);
    exp_t e;
    e.st = st; e.out = out; e.dur = 8'(dur); e.imm = imm;
    q.push_back(e);
  endtask

  // Expected path from WAIT_LOCK through WAIT_DLY entry; ev marks sticky error bits.
  task automatic push_front_half(input int wl_dur, input logic [7:0] ev);
    push(S_WL, O_RST | ev, wl_dur, 0);
    push(S_RA, O_RST | ev, 4, 0);
    push(S_RB, O_RBSC | ev, 4, 0);
    push(S_RS, O_RBS | ev, 1, 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [3:0] s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (seq_state !== s && n < 200);
    check("wait_state_reached", {28'd0, seq_state}, {28'd0, s});
  endtask

  // Monitor: every state change pops an expectation, checks the new state, the previous
  // state's dwell time, and the registered outputs (same cycle for resets, else one cycle later).
  task automatic monitor();
    logic [3:0] last_st;
    exp_t       cur;
    bit         pend;
    int         dcnt;
    last_st = 4'hF;
    pend    = 0;
    dcnt    = 0;
    cur     = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          check("outputs", {24'd0, bsc_rst, bs_rst, rst_dly, bsc_en_vtc, bs_en_vtc, logic_reset, seq_done, seq_error},
                {24'd0, cur.out});
          pend = 0;
        end
        if (seq_state !== last_st) begin
          if (last_st != 4'hF && cur.dur != 0) check("duration", dcnt, {24'd0, cur.dur});
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_transition: got state %0d want no change", seq_state);
          end else begin
            cur = q.pop_front();
            check("state", {28'd0, seq_state}, {28'd0, cur.st});
            if (cur.imm)
              check("outputs_now", {24'd0, bsc_rst, bs_rst, rst_dly, bsc_en_vtc, bs_en_vtc, logic_reset, seq_done, seq_error},
                    {24'd0, cur.out});
            else
              pend = 1;
          end
          last_st = seq_state;
          dcnt = 1;
        end else begin
          dcnt++;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b0; dly_rdy = 3'b000; vtc_rdy = 3'b000;
    fork monitor(); join_none
    push(S_WL, O_RST, 0, 1);
    cyc(2);
    mon_en = 1;
    cyc(1);
    reset = 1'b0;
    cyc(6);

    // Nominal bring-up: dly ready 2 cycles after WAIT_DLY entry, vtc 3 cycles after WAIT_VTC entry.
    push(S_RA, O_RST, 4, 0);
    push(S_RB, O_RBSC, 4, 0);
    push(S_RS, O_RBS, 1, 0);
    push(S_WD, O_RBS, 3, 0);
    push(S_EV, O_VTC, 1, 0);
    push(S_WV, O_VTC, 4, 0);
    push(S_DN, O_DONE, 0, 0);
    pll_locked = 1'b1;
    wait_state(S_WD);
    cyc(2);
    dly_rdy = 3'b111;
    wait_state(S_WV);
    cyc(3);
    vtc_rdy = 3'b111;
    wait_state(S_DN);
    cyc(3);

    // Reset pulse in DONE, then a masked run: nibble 1 never ready.
    push(S_WL, O_RST, 1, 1);
    push(S_RA, O_RST, 4, 0);
    push(S_RB, O_RBSC, 4, 0);
    push(S_RS, O_RBS, 1, 0);
    push(S_WD, O_RBS, 1, 0);
    push(S_EV, O_VTC, 1, 0);
    push(S_WV, O_VTC, 1, 0);
    push(S_DN, O_DONE, 0, 0);
    reset = 1'b1; dly_rdy = 3'b101; vtc_rdy = 3'b101;
    cyc(1);
    reset = 1'b0;
    wait_state(S_DN);
    vtc_rdy = 3'b000;
    cyc(3);

    // Lock loss in DONE, then again in WAIT_VTC, then a full run to DONE.
    push_front_half(2, 8'h00);
    push(S_WD, O_RBS, 1, 0);
    push(S_EV, O_VTC, 1, 0);
    push(S_WV, O_VTC, 3, 0);
    push_front_half(1, 8'h00);
    push(S_WD, O_RBS, 1, 0);
    push(S_EV, O_VTC, 1, 0);
    push(S_WV, O_VTC, 1, 0);
    push(S_DN, O_DONE, 0, 0);
    pll_locked = 1'b0;
    cyc(2);
    pll_locked = 1'b1;
    wait_state(S_WV);
    cyc(2);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    wait_state(S_WV);
    vtc_rdy = 3'b101;
    wait_state(S_DN);
    cyc(2);

    // dly ready on the exact timeout cycle: ready wins.
    dly_rdy = 3'b011;
    push_front_half(2, 8'h00);
    push(S_WD, O_RBS, 16, 0);
    push(S_EV, O_VTC, 1, 0);
    push(S_WV, O_VTC, 1, 0);
    push(S_DN, O_DONE, 0, 0);
    pll_locked = 1'b0;
    cyc(2);
    pll_locked = 1'b1;
    wait_state(S_WD);
    cyc(15);
    dly_rdy = 3'b101;
    wait_state(S_DN);
    cyc(2);

    // dly stuck with nibble 2 low: timeout into ERROR.
    dly_rdy = 3'b011;
    push_front_half(2, 8'h00);
    push(S_WD, O_RBS, 16, 0);
`ifdef BITSLICE_SEQ_RETRY_EN
    push(S_ER, O_ERR, 4, 0);
    push_front_half(1, 8'h01);
    push(S_WD, O_RBS | 8'h01, 1, 0);
    push(S_EV, O_VTC | 8'h01, 1, 0);
    push(S_WV, O_VTC | 8'h01, 1, 0);
    push(S_DN, O_DONE | 8'h01, 0, 0);
`else
    push(S_ER, O_ERR, 0, 0);
`endif
    pll_locked = 1'b0;
    cyc(2);
    pll_locked = 1'b1;
    wait_state(S_ER);
`ifdef BITSLICE_SEQ_RETRY_EN
    dly_rdy = 3'b101;
    wait_state(S_DN);
    cyc(3);
`else
    cyc(3);
    pll_locked = 1'b0;
    cyc(3);
    pll_locked = 1'b1;
    cyc(3);
    check("error_terminal", {28'd0, seq_state}, {28'd0, S_ER});
`endif

    // Final reset clears everything including the error flag.
    push(S_WL, O_RST, 0, 1);
    reset = 1'b1; pll_locked = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
